vga_matrix_renderer: RTL and testbench
======================================

# vga_matrix_renderer

Pixel-domain stage that consumes the raster position, sync and blanking outputs of the horizontal and vertical counters and produces registered 12-bit RGB for the VGA port. It maps an N×N matrix grid onto the visible area, reads each cell's value from a dual-bank result RAM written by the matrix-multiply engine, and converts it to colour. Bank swaps are requested by the engine and committed only at the start of vertical blanking, so the displayed matrix never tears.

## Interface
- N, 4: matrix dimension; power of two, 2..16.
- DATA_W, 16: cell value width; ≥12.
- CELL_SHIFT, 5: log2 of the cell size in pixels (square cells, 32×32).
- GRID_X0, 192: first grid column in pixels.
- GRID_Y0, 112: first grid line in pixels.
- ADDR_W, 1+2·log2(N): RAM address width (derived; not overridable).
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- clk_en  in  1  pixel enable; every register below advances only when high.
- h_count  in  11  horizontal position.
- v_count  in  10  vertical position.
- hsync_in / vsync_in  in  1  active-low syncs from the counters.
- hblank / vblank  in  1  blanking flags.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  {bank, row, col}.
- mem_rdata  in  DATA_W  RAM data, registered 1 clk after mem_rd_en; held while mem_rd_en is low.
- swap_req  in  1  engine requests a display-bank toggle (level; held until swap_ack).
- swap_ack  out  1  one-clk pulse when the toggle commits.
- disp_bank  out  1  bank currently displayed.
- vga_r / vga_g / vga_b  out  4 each  colour.
- vga_hs / vga_vs  out  1  syncs aligned with the colour.

## Operation
- Stage 1 (S1): in_grid = h in [GRID_X0, GRID_X0+N<<CELL_SHIFT) and v likewise, with blanking low. col = (h−GRID_X0)>>CELL_SHIFT and row = (v−GRID_Y0)>>CELL_SHIFT, both truncated to log2(N) bits. Subtract in 11 bits; in_grid is decided before truncation. mem_rd_en = clk_en & in_grid; mem_addr = {disp_bank, row, col}.
- Stage 2 (S2): capture mem_rdata, in_grid, edge flag and syncs.
- Stage 3 (S3): colour. Outside the grid or blanking gives 0,0,0. Inside the grid with value ≥ 2^12 (any bit above bit 11 set) gives saturated 0xF,0,0. Otherwise r=value[11:8], g=value[7:4], b=value[3:0].
- Swap FSM, two states:
  - IDLE: swap_req goes to PEND.
  - PEND: on the vblank rising edge (vblank high this clk_en, low the previous clk_en), toggle disp_bank, pulse swap_ack, return to IDLE.
  - swap_req dropping in PEND (protocol violation) returns the FSM to IDLE with no toggle.
  - A request arriving exactly on the vblank rising edge commits at the next frame, not this one.
- Reset mid-frame: pipeline cleared, FSM to IDLE, disp_bank=0. A pending request is lost; the engine must re-request.

## Timing
- Pixel-to-colour latency: 3 clk_en cycles. vga_hs/vga_vs are delayed by the same 3 stages, so colour and sync stay aligned.
- RAM read: address issued in S1; data sampled at the next clk_en, valid only if clk_en is spaced at least 1 clk apart (always true).
- swap_ack: one clk, asserted in the same clk that disp_bank changes. The new bank affects mem_addr from the next clk_en.
- Reset values: vga_r/g/b=0, vga_hs=1, vga_vs=1, mem_rd_en=0, mem_addr=0, swap_ack=0, disp_bank=0, FSM=IDLE. Pipeline valid bits are cleared, so the first 3 pixels after reset are black.

## Configuration
- VGA_GRID_LINES_EN defined: S1 also flags edge = in_grid with the low CELL_SHIFT bits of the x or y offset equal to 0. S3 outputs white 0xF,0xF,0xF on edge pixels, overriding the value colour. The grid's closing right and bottom line is drawn at offset N<<CELL_SHIFT, which lies outside in_grid but is included in the edge check.
- Undefined: no edge logic; cells are drawn flush.

## Structure
- Package vga_pkg: timing constants (visible, porch and sync widths), colour width 4, the WHITE/BLACK/SAT_RED constants, and the swap-state enum.
- One sub-module, vga_bank_swap: the swap FSM plus vblank edge detection. The pipeline stays in the top module.

## Test plan
- Reset pixel=(0,0), pipeline filled, mem_rdata=0x0ABC at cell (0,0) → 3 clk_en later rgb=A,B,C; vga_hs/vga_vs match the input delayed 3 clk_en.
- Sweep h across GRID_X0−1, GRID_X0, GRID_X0+127, GRID_X0+128 on an in-grid line → mem_rd_en 0,1,1,0; cols 0 and 3.
- mem_rdata=0x1000 → rgb=F,0,0; mem_rdata=0x0FFF → rgb=F,F,F (with the macro undefined).
- swap_req raised mid-frame → swap_ack 1 clk at the next vblank rising edge, disp_bank 0→1, mem_addr MSB=1 from the next read. Request on the edge clk commits one frame later.
- Reset asserted in PEND → disp_bank=0, no swap_ack, all outputs at reset values.
- VGA_GRID_LINES_EN defined: pixel (GRID_X0+32, GRID_Y0+5) → white; (GRID_X0+33, GRID_Y0+5) → value colour.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA matrix renderer.
// Holds 640x480 timing, colour constants and the bank-swap state type.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int COLOR_W = 4;

  localparam logic [3*COLOR_W-1:0] WHITE   = 12'hFFF;
  localparam logic [3*COLOR_W-1:0] BLACK   = 12'h000;
  localparam logic [3*COLOR_W-1:0] SAT_RED = 12'hF00;

  typedef enum logic {
    SWAP_IDLE = 1'b0,
    SWAP_PEND = 1'b1
  } swap_state_e;

endpackage

// File: rtl/vga_matrix_renderer_if.sv
// Result-RAM read port and bank-swap handshake between renderer and engine.
// The renderer side uses the master modport; RAM/engine side uses slave.
interface vga_matrix_renderer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              swap_req;
  logic              swap_ack;

  modport master (
    output mem_rd_en,
    output mem_addr,
    output swap_ack,
    input  mem_rdata,
    input  swap_req
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    input  swap_ack,
    output mem_rdata,
    output swap_req
  );

endinterface

// File: rtl/vga_bank_swap.sv
// Display-bank swap FSM; commits a requested toggle on the vblank rising edge.
//   state     | meaning
//   SWAP_IDLE | no request outstanding
//   SWAP_PEND | request seen, waiting for the next vblank rising edge
module vga_bank_swap
  import vga_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clk_en,
  input  logic vblank,
  input  logic swap_req,
  output logic swap_ack,
  output logic disp_bank
);

  swap_state_e state_q, state_d;
  logic        vblank_prev_q;
  logic        ack_q;
  logic        bank_q;
  logic        commit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= SWAP_IDLE;
      vblank_prev_q <= 1'b0;
      ack_q         <= 1'b0;
      bank_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= commit;
      bank_q  <= bank_q ^ commit;
      if (clk_en) vblank_prev_q <= vblank;
    end
  end

  // A request seen in IDLE on the edge itself only reaches PEND, so it waits a frame.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    if (clk_en) begin
      case (state_q)
        SWAP_IDLE: if (swap_req) state_d = SWAP_PEND;
        SWAP_PEND: begin
          if (!swap_req) begin
            state_d = SWAP_IDLE;
          end else if (vblank && !vblank_prev_q) begin
            commit  = 1'b1;
            state_d = SWAP_IDLE;
          end
        end
        default: state_d = SWAP_IDLE;
      endcase
    end
  end

  assign swap_ack  = ack_q;
  assign disp_bank = bank_q;

endmodule

// File: rtl/vga_matrix_renderer.sv
// Maps an N x N result matrix onto the screen and produces registered 12-bit RGB.
// Optional grid-line overlay is enabled with the VGA_GRID_LINES_EN macro.
module vga_matrix_renderer
  import vga_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_W     = 16,
  parameter int CELL_SHIFT = 5,
  parameter int GRID_X0    = 192,
  parameter int GRID_Y0    = 112
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clk_en,
  input  logic [10:0]         h_count,
  input  logic [9:0]          v_count,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                hblank,
  input  logic                vblank,
  vga_matrix_renderer_if.master bus,
  output logic                disp_bank,
  output logic [COLOR_W-1:0]  vga_r,
  output logic [COLOR_W-1:0]  vga_g,
  output logic [COLOR_W-1:0]  vga_b,
  output logic                vga_hs,
  output logic                vga_vs
);

  localparam int LOG_N  = $clog2(N);
  localparam int ADDR_W = 1 + 2 * LOG_N;
  localparam logic [10:0] X0   = 11'(GRID_X0);
  localparam logic [10:0] Y0   = 11'(GRID_Y0);
  localparam logic [10:0] SPAN = 11'(N << CELL_SHIFT);

  logic [10:0]      x_off, y_off;
  logic             x_in, y_in, blank, in_grid;
  logic [LOG_N-1:0] row, col;
  logic             grid_line;

  logic             in_grid_q1, line_q1, hs_q1, vs_q1;
  logic [DATA_W-1:0] value_q2;
  logic             in_grid_q2, line_q2, hs_q2, vs_q2;
  logic [11:0]      rgb_q, rgb_d;
  logic             hs_q3, vs_q3;

  // S1: grid membership is decided on the full 11-bit offset, before truncation.
  assign x_off   = h_count - X0;
  assign y_off   = {1'b0, v_count} - Y0;
  assign x_in    = (h_count >= X0) && (x_off < SPAN);
  assign y_in    = ({1'b0, v_count} >= Y0) && (y_off < SPAN);
  assign blank   = hblank | vblank;
  assign in_grid = x_in && y_in && !blank;
  assign col     = x_off[CELL_SHIFT +: LOG_N];
  assign row     = y_off[CELL_SHIFT +: LOG_N];

`ifdef VGA_GRID_LINES_EN
  logic x_line_rng, y_line_rng, on_line;
  // Range is closed so the right and bottom border line is drawn too.
  assign x_line_rng = (h_count >= X0) && (x_off <= SPAN);
  assign y_line_rng = ({1'b0, v_count} >= Y0) && (y_off <= SPAN);
  assign on_line    = (x_off[CELL_SHIFT-1:0] == '0) || (y_off[CELL_SHIFT-1:0] == '0);
  assign grid_line  = x_line_rng && y_line_rng && !blank && on_line;
`else
  assign grid_line  = 1'b0;
`endif

  assign bus.mem_rd_en = reset_n & clk_en & in_grid;
  assign bus.mem_addr  = reset_n ? ADDR_W'({disp_bank, row, col}) : '0;

  vga_bank_swap u_bank_swap (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk_en    (clk_en),
    .vblank    (vblank),
    .swap_req  (bus.swap_req),
    .swap_ack  (bus.swap_ack),
    .disp_bank (disp_bank)
  );

  always_comb begin
    rgb_d = BLACK;
    if (line_q2) begin
      rgb_d = WHITE;
    end else if (in_grid_q2) begin
      if ((value_q2 >> 12) != '0) rgb_d = SAT_RED;
      else                        rgb_d = value_q2[11:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_grid_q1 <= 1'b0;
      line_q1    <= 1'b0;
      hs_q1      <= 1'b1;
      vs_q1      <= 1'b1;
      value_q2   <= '0;
      in_grid_q2 <= 1'b0;
      line_q2    <= 1'b0;
      hs_q2      <= 1'b1;
      vs_q2      <= 1'b1;
      rgb_q      <= BLACK;
      hs_q3      <= 1'b1;
      vs_q3      <= 1'b1;
    end else if (clk_en) begin
      in_grid_q1 <= in_grid;
      line_q1    <= grid_line;
      hs_q1      <= hsync_in;
      vs_q1      <= vsync_in;
      value_q2   <= bus.mem_rdata;
      in_grid_q2 <= in_grid_q1;
      line_q2    <= line_q1;
      hs_q2      <= hs_q1;
      vs_q2      <= vs_q1;
      rgb_q      <= rgb_d;
      hs_q3      <= hs_q2;
      vs_q3      <= vs_q2;
    end
  end

  assign vga_r  = rgb_q[11:8];
  assign vga_g  = rgb_q[7:4];
  assign vga_b  = rgb_q[3:0];
  assign vga_hs = hs_q3;
  assign vga_vs = vs_q3;

endmodule

// File: tb/tb_vga_matrix_renderer.sv
// Testbench for vga_matrix_renderer: random pixels against a cell-level colour model.
// Grid-line expectations follow VGA_GRID_LINES_EN when it is defined.
module tb_vga_matrix_renderer;

  localparam int X0   = 192;
  localparam int Y0   = 112;
  localparam int CELL = 32;
  localparam int SPAN = 4 * CELL;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic        hsync_in, vsync_in, hblank, vblank;
  logic        disp_bank;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram [32];
  logic        mdl_bank;
  exp_t        q[$];
  exp_t        last_exp;
  exp_t        idle_exp;
  logic        rd_s, rd_exp;
  logic [4:0]  addr_s, addr_exp;

  vga_matrix_renderer_if #(.ADDR_W(5), .DATA_W(16)) bus ();

  vga_matrix_renderer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk_en    (clk_en),
    .h_count   (h_count),
    .v_count   (v_count),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .hblank    (hblank),
    .vblank    (vblank),
    .bus       (bus),
    .disp_bank (disp_bank),
    .vga_r     (vga_r),
    .vga_g     (vga_g),
    .vga_b     (vga_b),
    .vga_hs    (vga_hs),
    .vga_vs    (vga_vs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_n)           bus.mem_rdata <= 16'h0;
    else if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end

  function automatic bit in_grid_m(int h, int v, logic hb, logic vb);
    return !hb && !vb && h >= X0 && h < X0 + SPAN && v >= Y0 && v < Y0 + SPAN;
  endfunction

  function automatic logic [11:0] rgb_m(int h, int v, logic hb, logic vb);
    int val;
`ifdef VGA_GRID_LINES_EN
    if (!hb && !vb && h >= X0 && h <= X0 + SPAN && v >= Y0 && v <= Y0 + SPAN)
      if ((h - X0) % CELL == 0 || (v - Y0) % CELL == 0) return 12'hFFF;
`endif
    if (!in_grid_m(h, v, hb, vb)) return 12'h000;
    val = int'(ram[int'(mdl_bank) * 16 + ((v - Y0) / CELL) * 4 + (h - X0) / CELL]);
    if (val >= 4096) return 12'hF00;
    return 12'(val);
  endfunction

  task automatic reinit_model();
    q.delete();
    q.push_back(idle_exp);
    q.push_back(idle_exp);
    last_exp = idle_exp;
    mdl_bank = 1'b0;
  endtask

  // Drives one clock of pixel inputs; captures the read port and advances the model.
  task automatic pix(input int h, input int v, input logic hs, input logic vs,
                     input logic hb, input logic vb, input logic en);
    exp_t e;
    h_count  = 11'(h);
    v_count  = 10'(v);
    hsync_in = hs;
    vsync_in = vs;
    hblank   = hb;
    vblank   = vb;
    clk_en   = en;
    #1;
    rd_s     = bus.mem_rd_en;
    addr_s   = bus.mem_addr;
    rd_exp   = en && reset_n && in_grid_m(h, v, hb, vb);
    addr_exp = rd_exp ? 5'(int'(mdl_bank) * 16 + ((v - Y0) / CELL) * 4 + (h - X0) / CELL) : 5'd0;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      reinit_model();
    end else if (en) begin
      e.rgb = rgb_m(h, v, hb, vb);
      e.hs  = hs;
      e.vs  = vs;
      q.push_back(e);
      last_exp = q.pop_front();
    end
  endtask

  task automatic test_reset();
    ram[0] = 16'h0ABC;
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h000 || vga_hs !== 1'b1 || vga_vs !== 1'b1) begin
      errors++;
      $display("FAIL reset_out: got rgb=%h hs=%b vs=%b, required 000 1 1", {vga_r, vga_g, vga_b}, vga_hs, vga_vs);
    end
    checks++;
    if (rd_s !== 1'b0 || addr_s !== 5'd0 || bus.swap_ack !== 1'b0 || disp_bank !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: got rd=%b addr=%h ack=%b bank=%b, required 0 0 0 0", rd_s, addr_s, bus.swap_ack, disp_bank);
    end
    reset_n = 1'b1;
    pix(200, 120, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({vga_r, vga_g, vga_b} !== 12'h000 || vga_hs !== 1'b1) begin
        errors++;
        $display("FAIL fill_black%0d: got rgb=%h hs=%b, required 000 1", i, {vga_r, vga_g, vga_b}, vga_hs);
      end
      pix(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'hABC || vga_hs !== 1'b0 || vga_vs !== 1'b1) begin
      errors++;
      $display("FAIL first_pixel: got rgb=%h hs=%b vs=%b, required abc 0 1", {vga_r, vga_g, vga_b}, vga_hs, vga_vs);
    end
  endtask

  task automatic test_sweep();
    int hs_tab[4] = '{X0 - 1, X0, X0 + 127, X0 + 128};
    logic rd_tab[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] col_tab[4] = '{2'd0, 2'd0, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      pix(hs_tab[i], Y0 + 40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (rd_s !== rd_tab[i] || (rd_tab[i] && addr_s !== {1'b0, 2'd1, col_tab[i]})) begin
        errors++;
        $display("FAIL sweep h=%0d: got rd=%b addr=%h, required rd=%b addr=%h", hs_tab[i], rd_s, addr_s, rd_tab[i], {1'b0, 2'd1, col_tab[i]});
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] vals[2] = '{16'h1000, 16'h0FFF};
    logic [11:0] want[2] = '{12'hF00, 12'hFFF};
    for (int i = 0; i < 2; i++) begin
      ram[5] = vals[i];
      pix(X0 + 40, Y0 + 40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) pix(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({vga_r, vga_g, vga_b} !== want[i]) begin
        errors++;
        $display("FAIL sat value=%h: got rgb=%h, required %h", vals[i], {vga_r, vga_g, vga_b}, want[i]);
      end
    end
  endtask

  task automatic test_random();
    int h, v;
    logic hb, vb, en;
    for (int i = 0; i < 32; i++) ram[i] = 16'($urandom_range(0, 16'h1FFF));
    for (int n = 0; n < 400; n++) begin
      h  = $urandom_range(150, 360);
      v  = $urandom_range(90, 260);
      hb = ($urandom_range(0, 9) == 0);
      vb = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 3) != 0);
      pix(h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), hb, vb, en);
      checks++;
      if (rd_s !== rd_exp || (rd_exp && addr_s !== addr_exp)) begin
        errors++;
        $display("FAIL rand_read h=%0d v=%0d: got rd=%b addr=%h, required rd=%b addr=%h", h, v, rd_s, addr_s, rd_exp, addr_exp);
      end
      checks++;
      if ({vga_r, vga_g, vga_b} !== last_exp.rgb || vga_hs !== last_exp.hs || vga_vs !== last_exp.vs) begin
        errors++;
        $display("FAIL rand_pix %0d: got rgb=%h hs=%b vs=%b, required rgb=%h hs=%b vs=%b", n, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, last_exp.rgb, last_exp.hs, last_exp.vs);
      end
    end
  endtask

  task automatic test_swap();
    bus.swap_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix(X0 + 8, Y0 + 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (bus.swap_ack !== 1'b0 || disp_bank !== 1'b0) begin
        errors++;
        $display("FAIL swap_wait%0d: got ack=%b bank=%b, required 0 0", i, bus.swap_ack, disp_bank);
      end
    end
    pix(0, 300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.swap_ack !== 1'b1 || disp_bank !== 1'b1) begin
      errors++;
      $display("FAIL swap_commit: got ack=%b bank=%b, required 1 1", bus.swap_ack, disp_bank);
    end
    mdl_bank = 1'b1;
    bus.swap_req = 1'b0;
    pix(0, 301, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.swap_ack !== 1'b0 || disp_bank !== 1'b1) begin
      errors++;
      $display("FAIL swap_pulse: got ack=%b bank=%b, required 0 1", bus.swap_ack, disp_bank);
    end
    pix(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    pix(X0 + 8, Y0 + 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (rd_s !== 1'b1 || addr_s !== 5'b10000) begin
      errors++;
      $display("FAIL swap_addr: got rd=%b addr=%h, required 1 10", rd_s, addr_s);
    end
    // Request raised on the very clock vblank rises must wait a frame.
    pix(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.swap_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix(0, 300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (bus.swap_ack !== 1'b0 || disp_bank !== 1'b1) begin
        errors++;
        $display("FAIL edge_req%0d: got ack=%b bank=%b, required 0 1", i, bus.swap_ack, disp_bank);
      end
    end
    for (int i = 0; i < 3; i++) pix(X0 + 40, Y0 + 70, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({vga_r, vga_g, vga_b} !== last_exp.rgb) begin
      errors++;
      $display("FAIL bank1_pix: got rgb=%h, required %h", {vga_r, vga_g, vga_b}, last_exp.rgb);
    end
    pix(0, 300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.swap_ack !== 1'b1 || disp_bank !== 1'b0) begin
      errors++;
      $display("FAIL edge_commit: got ack=%b bank=%b, required 1 0", bus.swap_ack, disp_bank);
    end
    mdl_bank = 1'b0;
    bus.swap_req = 1'b0;
    pix(0, 301, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_pend();
    bus.swap_req = 1'b1;
    pix(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    pix(0, 300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (disp_bank !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_bank: got bank=%b, required 1", disp_bank);
    end
    mdl_bank = 1'b1;
    bus.swap_req = 1'b0;
    pix(0, 301, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    ram[16] = 16'h0567;
    bus.swap_req = 1'b1;
    for (int i = 0; i < 4; i++) pix(X0 + 8, Y0 + 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    pix(0, 300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.swap_ack !== 1'b0 || disp_bank !== 1'b0 || rd_s !== 1'b0 || addr_s !== 5'd0) begin
      errors++;
      $display("FAIL reset_pend_ctl: got ack=%b bank=%b rd=%b addr=%h, required 0 0 0 0", bus.swap_ack, disp_bank, rd_s, addr_s);
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h000 || vga_hs !== 1'b1 || vga_vs !== 1'b1) begin
      errors++;
      $display("FAIL reset_pend_out: got rgb=%h hs=%b vs=%b, required 000 1 1", {vga_r, vga_g, vga_b}, vga_hs, vga_vs);
    end
    reset_n = 1'b1;
    bus.swap_req = 1'b0;
    pix(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    pix(0, 300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.swap_ack !== 1'b0 || disp_bank !== 1'b0) begin
      errors++;
      $display("FAIL lost_req: got ack=%b bank=%b, required 0 0", bus.swap_ack, disp_bank);
    end
  endtask

`ifdef VGA_GRID_LINES_EN
  task automatic test_grid_lines();
    int xs[2] = '{X0 + 32, X0 + 33};
    ram[1] = 16'h0123;
    for (int i = 0; i < 2; i++) begin
      pix(xs[i], Y0 + 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) pix(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({vga_r, vga_g, vga_b} !== (i == 0 ? 12'hFFF : 12'h123)) begin
        errors++;
        $display("FAIL grid_line x=%0d: got rgb=%h, required %h", xs[i], {vga_r, vga_g, vga_b}, (i == 0 ? 12'hFFF : 12'h123));
      end
    end
  endtask
`endif

  initial begin
    idle_exp.rgb = 12'h000;
    idle_exp.hs  = 1'b1;
    idle_exp.vs  = 1'b1;
    for (int i = 0; i < 32; i++) ram[i] = 16'h0;
    reset_n      = 1'b0;
    bus.swap_req = 1'b0;
    reinit_model();
    for (int i = 0; i < 3; i++) pix(X0 + 8, Y0 + 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_sweep();
    test_saturation();
    test_random();
    test_swap();
    test_reset_pend();
`ifdef VGA_GRID_LINES_EN
    test_grid_lines();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
